// File: rtl/ws2812_frame_buffer_pkg.sv
// +----------------------------------------------------------------------------+
// | ws2812_frame_buffer_pkg                                                    |
// | Shared pixel-format constants and FSM state encoding for the frame buffer. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package ws2812_frame_buffer_pkg;

  localparam int PIXEL_W = 24;
  localparam int G_LSB   = 16;
  localparam int R_LSB   = 8;
  localparam int B_LSB   = 0;
  localparam int CLK_HZ  = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ws2812_pixel_ram.sv
// +----------------------------------------------------------------------------+
// | ws2812_pixel_ram                                                           |
// | Simple dual-port pixel store, one write and one registered read port.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ws2812_pixel_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W:0]   i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W:0]   i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // MSB of the address is the bank; each bank spans the full index space.
  logic [DATA_W-1:0] r_mem [0:(2**(ADDR_W+1))-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ws2812_frame_buffer.sv
// +----------------------------------------------------------------------------+
// | ws2812_frame_buffer                                                        |
// | Double-buffered GRB pixel store streaming frames to the WS2812 serializer.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ws2812_frame_buffer
  import ws2812_frame_buffer_pkg::*;
#(
  parameter int NUM_LEDS       = 60,
  parameter int ADDR_W         = 10,
  parameter int REFRESH_CYCLES = 833333
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [PIXEL_W-1:0] i_wr_data,
  input  logic               i_commit,
  input  logic               i_start,
  output logic [PIXEL_W-1:0] o_pix_data,
  output logic               o_pix_valid,
  output logic               o_pix_last,
  input  logic               i_pix_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W:0]   c_num_leds = (ADDR_W+1)'(NUM_LEDS);

  state_t             r_state;
  logic               r_front_sel;
  logic               r_start_pend;
  logic               r_commit_pend;
  logic               r_tick_pend;
  logic [ADDR_W-1:0]  r_idx;
  logic [PIXEL_W-1:0] r_pix_data;
  logic               r_pix_valid;
  logic               r_pix_last;
  logic               r_busy;
  logic               r_done;

  logic               w_tick;
  logic               w_frame_start;
  logic               w_swap;
  logic               w_front_next;
  logic               w_is_last;
  logic               w_advance;
  logic               w_rd_en;
  logic [ADDR_W-1:0]  w_rd_idx;
  logic               w_wr_ok;
  logic [PIXEL_W-1:0] w_ram_q;

  assign w_frame_start = (r_state == ST_IDLE) && (r_start_pend || r_commit_pend || r_tick_pend);
  assign w_swap        = w_frame_start && r_commit_pend;
  // Bank roles as they will be after this cycle, so reads and writes on S already see the swap.
  assign w_front_next  = r_front_sel ^ w_swap;
  assign w_is_last     = (r_idx == c_last_idx);
  assign w_advance     = (r_state == ST_PRESENT) && r_pix_valid && i_pix_ready && !w_is_last;
  assign w_rd_en       = w_frame_start || w_advance;
  assign w_rd_idx      = w_advance ? (r_idx + 1'b1) : '0;
  assign w_wr_ok       = i_wr_en && ({1'b0, i_wr_addr} < c_num_leds);

  ws2812_pixel_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (PIXEL_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr ({~w_front_next, i_wr_addr}),
    .i_wdata (i_wr_data),
    .i_re    (w_rd_en),
    .i_raddr ({w_front_next, w_rd_idx}),
    .o_rdata (w_ram_q)
  );

  generate
    if (REFRESH_CYCLES > 0) begin : g_refresh
      localparam int            c_cnt_w  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
      localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(REFRESH_CYCLES - 1);
      logic [c_cnt_w-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= c_reload;
        end else if (r_cnt == '0) begin
          r_cnt <= c_reload;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end

      assign w_tick = (r_cnt == '0);
    end else begin : g_no_refresh
      assign w_tick = 1'b0;
    end
  endgenerate

  // A request arriving on the start cycle itself stays pending for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_pend  <= 1'b0;
      r_commit_pend <= 1'b0;
      r_tick_pend   <= 1'b0;
    end else begin
      r_start_pend  <= i_start  || (r_start_pend  && !w_frame_start);
      r_commit_pend <= i_commit || (r_commit_pend && !w_frame_start);
      r_tick_pend   <= w_tick   || (r_tick_pend   && !w_frame_start);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_front_sel <= 1'b0;
      r_idx       <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_frame_start) begin
            r_idx       <= '0;
            r_front_sel <= w_front_next;
            r_busy      <= 1'b1;
            r_state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_pix_data  <= w_ram_q;
          r_pix_valid <= 1'b1;
          r_pix_last  <= w_is_last;
          r_state     <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (i_pix_ready) begin
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
            if (w_is_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_FETCH;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_pix_data  = r_pix_data;
  assign o_pix_valid = r_pix_valid;
  assign o_pix_last  = r_pix_last;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

`default_nettype wire
